mips_instr_encoder: RTL

Streaming instruction encoder and instruction-memory loader for the single-cycle MIPS core. It accepts field-level descriptions of R-type, lw, sw and beq instructions over a valid/ready handshake and packs each one into a 32-bit MIPS word. It then writes the words sequentially into instruction memory, so benches and boot logic can build programs that the core's control decoder consumes. It is the encode side of the opcode/field format the control unit decodes.

---
 rtl/mips_isa_pkg.sv | 33 +++
 rtl/mips_instr_encoder_if.sv | 31 +++
 rtl/mips_word_pack.sv | 26 ++
 rtl/mips_instr_encoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the instruction encoder and the control decoder.
// Opcodes, the supported R-type funct codes, the kind enum and the encoder FSM states.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    KindR   = 2'd0,
    KindLw  = 2'd1,
    KindSw  = 2'd2,
    KindBeq = 2'd3
  } instrKind_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StFull = 2'd2
  } encState_t;

  function automatic logic isLegalFunct(input logic [5:0] funct);
    return funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Field-level instruction input handshake plus the instruction-memory write side.
// The slave modport is the encoder's view; the master modport is the producer's view.
interface mips_instr_encoder_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, full, err
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, full, err
  );
endinterface

// File: rtl/mips_word_pack.sv
// Combinational packer: instruction fields to a 32-bit MIPS word.
module mips_word_pack
  import mips_isa_pkg::*;
(
  input  instrKind_t  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    unique case (kind_i)
      KindR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      KindLw:  word_o = {OP_LW, rs_i, rt_i, imm_i};
      KindSw:  word_o = {OP_SW, rs_i, rt_i, imm_i};
      KindBeq: word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder and sequential instruction-memory loader.
// Optional build macro ENC_CHECK_EN drops R-type words with unsupported funct and flags err.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  mips_instr_encoder_if.slave bus
);

  localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);

  encState_t         stateQ, stateD;
  logic [ADDR_W:0]   countQ, countD;
  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic [31:0]       packedWord;
  logic              xfer;
  logic              illegal;
  logic              doWrite;

  mips_word_pack u_pack (
    .kind_i  (instrKind_t'(bus.in_kind)),
    .rs_i    (bus.in_rs),
    .rt_i    (bus.in_rt),
    .rd_i    (bus.in_rd),
    .shamt_i (bus.in_shamt),
    .funct_i (bus.in_funct),
    .imm_i   (bus.in_imm),
    .word_o  (packedWord)
  );

  assign bus.in_ready = (stateQ != StFull);
  assign xfer         = bus.in_valid && bus.in_ready;

`ifdef ENC_CHECK_EN
  logic errQ, errD;
  assign illegal = xfer && (instrKind_t'(bus.in_kind) == KindR) && !isLegalFunct(bus.in_funct);
`else
  assign illegal = 1'b0;
`endif

  // clear discards any word presented in the same cycle
  assign doWrite = xfer && !illegal && !clear;

  always_comb begin
    stateD = stateQ;
    countD = countQ;
    if (clear) begin
      stateD = StIdle;
      countD = '0;
    end else if (doWrite) begin
      countD = countQ + 1'b1;
      stateD = (countD == DepthCount) ? StFull : StFill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      countQ <= '0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
      weQ    <= doWrite;
      if (doWrite) begin
        addrQ  <= countQ[ADDR_W-1:0];
        wdataQ <= packedWord;
      end
    end
  end

`ifdef ENC_CHECK_EN
  always_comb begin
    errD = errQ;
    if (clear) begin
      errD = 1'b0;
    end else if (illegal) begin
      errD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errQ <= 1'b0;
    end else begin
      errQ <= errD;
    end
  end

  assign bus.err = errQ;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.imem_we    = weQ;
  assign bus.imem_addr  = addrQ;
  assign bus.imem_wdata = wdataQ;
  assign bus.word_count = countQ;
  assign bus.full       = (stateQ == StFull);

endmodule
